// File: rtl/game_pkg.sv
// Shared definitions for the runner game.
// The game controller, the obstacle mover and the renderer all import this
// package, so that state encodings and box geometry agree across the design.
//
// Contents:
//   gameState_t                   - 2-bit game state (IDLE / RUN / OVER)
//   DINO_X, DINO_W, DINO_H        - player box position and size, in pixels
//   OBS_W, OBS_H                  - obstacle box size, in pixels
//   OBS_X0, OBS_Y0                - obstacle position after reset
//   satInc()                      - 16-bit increment that stops at all-ones
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_OVER = 2'b10
   } gameState_t;

   localparam int DINO_X = 100;
   localparam int DINO_W = 40;
   localparam int DINO_H = 40;
   localparam int OBS_W  = 20;
   localparam int OBS_H  = 40;

   localparam int OBS_X0 = 900;
   localparam int OBS_Y0 = 400;

   // The score has to stick at its maximum rather than roll back to zero.
   function automatic logic [15:0] satInc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational intersection test between two axis-aligned boxes.
// Box A spans [aX, aX+A_W) x [aY, aY+A_H); box B spans [bX, bX+B_W) x
// [bY, bY+B_H). Edges that only touch do not count as overlapping.
//
// Ports:
//   aX, aY  in  10 - top-left corner of box A
//   bX, bY  in  10 - top-left corner of box B
//   hit     out 1  - boxes intersect
module box_overlap #(
   parameter int A_W = 40,
   parameter int A_H = 40,
   parameter int B_W = 20,
   parameter int B_H = 40
) (
   input  logic [9:0] aX,
   input  logic [9:0] aY,
   input  logic [9:0] bX,
   input  logic [9:0] bY,
   output logic       hit
);

   logic [10:0] aRight;
   logic [10:0] aBottom;
   logic [10:0] bRight;
   logic [10:0] bBottom;

   // Far edges are formed 11 bits wide so a box near the 10-bit limit
   // cannot wrap around and appear to sit on the left or top of the screen.
   always_comb begin
      aRight  = {1'b0, aX} + 11'(A_W);
      aBottom = {1'b0, aY} + 11'(A_H);
      bRight  = {1'b0, bX} + 11'(B_W);
      bBottom = {1'b0, bY} + 11'(B_H);
      hit = ({1'b0, bX} < aRight)  && (bRight  > {1'b0, aX}) &&
            ({1'b0, bY} < aBottom) && (bBottom > {1'b0, aY});
   end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller for the runner game.
// Sequences IDLE -> RUN -> OVER -> IDLE, counts obstacles the player gets
// past, detects collisions, and keeps the best score since reset. After a
// collision the jump button is locked out for HOLD_CYC cycles so a player
// still mashing the button does not restart by accident.
//
// Ports:
//   clk        in  1  - system clock
//   rst_n      in  1  - asynchronous active-low reset
//   jump       in  1  - jump button level (synchronized, debounced)
//   obtacle_x  in  10 - obstacle left edge
//   obtacle_y  in  10 - obstacle top edge
//   dino_y     in  10 - player top edge
//   state      out 2  - 00 IDLE, 01 RUN, 10 OVER
//   score      out 16 - current score
//   hi_score   out 16 - best score since reset
//   collide    out 1  - one-cycle pulse on RUN -> OVER
module game_ctrl #(
   parameter int DINO_X   = game_pkg::DINO_X,
   parameter int DINO_W   = game_pkg::DINO_W,
   parameter int DINO_H   = game_pkg::DINO_H,
   parameter int OBS_W    = game_pkg::OBS_W,
   parameter int OBS_H    = game_pkg::OBS_H,
   parameter int HOLD_CYC = 50_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        jump,
   input  logic [9:0]  obtacle_x,
   input  logic [9:0]  obtacle_y,
   input  logic [9:0]  dino_y,
   output logic [1:0]  state,
   output logic [15:0] score,
   output logic [15:0] hi_score,
   output logic        collide
);

   import game_pkg::*;

   // The counter only ever holds HOLD_CYC-1 down to 0.
   localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   gameState_t        stateQ;
   gameState_t        stateNext;
   logic [15:0]       scoreQ;
   logic [15:0]       scoreNext;
   logic [15:0]       hiQ;
   logic [15:0]       hiNext;
   logic              collideQ;
   logic              collideNext;
   logic [HOLD_W-1:0] holdQ;
   logic [HOLD_W-1:0] holdNext;

   logic              jumpQ;
   logic              jumpRise;
   logic [9:0]        prevX;
   logic              overlap;
   logic              pass;

   // Player box against obstacle box. The player's x position is fixed.
   box_overlap #(
      .A_W (DINO_W),
      .A_H (DINO_H),
      .B_W (OBS_W),
      .B_H (OBS_H)
   ) dinoVsObstacle (
      .aX  (10'(DINO_X)),
      .aY  (dino_y),
      .bX  (obtacle_x),
      .bY  (obtacle_y),
      .hit (overlap)
   );

   // Keep last cycle's button level and obstacle position so that a press
   // and the obstacle crossing the player's left edge can be seen as edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jumpQ <= 1'b0;
         prevX <= '0;
      end else begin
         jumpQ <= jump;
         prevX <= obtacle_x;
      end
   end

   // A pass is the obstacle moving from at-or-right-of the player's left
   // edge to strictly left of it. When the mover wraps the obstacle back to
   // the right side the position grows, so a wrap never looks like a pass.
   always_comb begin
      jumpRise = jump & ~jumpQ;
      pass     = (prevX >= 10'(DINO_X)) && (obtacle_x < 10'(DINO_X));
   end

   // Every output comes straight from these registers, so nothing on the
   // input side can reach an output without going through a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ   <= ST_IDLE;
         scoreQ   <= '0;
         hiQ      <= '0;
         collideQ <= 1'b0;
         holdQ    <= '0;
      end else begin
         stateQ   <= stateNext;
         scoreQ   <= scoreNext;
         hiQ      <= hiNext;
         collideQ <= collideNext;
         holdQ    <= holdNext;
      end
   end

   // Next-state logic. A collision outranks a pass in the same cycle, so
   // the obstacle that kills the player never adds to the score. In OVER
   // the counter must reach zero before a fresh press is honoured; a button
   // held down through the end of the lockout produces no rise and is
   // therefore ignored.
   always_comb begin
      stateNext   = stateQ;
      scoreNext   = scoreQ;
      hiNext      = hiQ;
      collideNext = 1'b0;
      holdNext    = holdQ;

      case (stateQ)
         ST_IDLE: begin
            scoreNext = '0;
            if (jumpRise) begin
               stateNext = ST_RUN;
            end
         end

         ST_RUN: begin
            if (overlap) begin
               stateNext   = ST_OVER;
               collideNext = 1'b1;
               holdNext    = HOLD_W'(HOLD_CYC - 1);
               if (scoreQ > hiQ) begin
                  hiNext = scoreQ;
               end
            end else if (pass) begin
               scoreNext = satInc(scoreQ);
            end
         end

         ST_OVER: begin
            if (holdQ != '0) begin
               holdNext = holdQ - 1'b1;
            end else if (jumpRise) begin
               stateNext = ST_IDLE;
               scoreNext = '0;
            end
         end

         default: begin
            stateNext = ST_IDLE;
            scoreNext = '0;
         end
      endcase
   end

   always_comb begin
      state    = stateQ;
      score    = scoreQ;
      hi_score = hiQ;
      collide  = collideQ;
   end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-flow controller for the runner game. It drives the `state` and `score` buses consumed by the obstacle mover and the renderer. It reads back the obstacle position and the player's vertical position, detects collisions and obstacle passes, and sequences idle, run and game-over. It is the producing end of the state/score ↔ obstacle-position loop.

## Interface
- `DINO_X`, 100: fixed left edge of the player box, in pixels.
- `DINO_W`, 40: player box width.
- `DINO_H`, 40: player box height.
- `OBS_W`, 20: obstacle box width.
- `OBS_H`, 40: obstacle box height.
- `HOLD_CYC`, 50_000_000: game-over lockout in clock cycles, during which `jump` is ignored.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `jump` in 1: jump button level, already synchronized and debounced.
- `obtacle_x` in 10: obstacle left edge, in pixels.
- `obtacle_y` in 10: obstacle top edge, in pixels.
- `dino_y` in 10: player top edge, in pixels.
- `state` out 2: game state. 00 = IDLE, 01 = RUN, 10 = OVER. 11 is never driven.
- `score` out 16: current score.
- `hi_score` out 16: best score since reset.
- `collide` out 1: one-cycle pulse on the RUN→OVER transition.

## Operation
- Jump edge detection:
  - `jump_q` is a registered copy of `jump`.
  - `jump_rise = jump & ~jump_q`.
- Overlap is combinational, with all sums computed 11 bits wide so nothing wraps. Overlap is true only when all four of these hold:
  - `obtacle_x < DINO_X+DINO_W`
  - `obtacle_x+OBS_W > DINO_X`
  - `obtacle_y < dino_y+DINO_H`
  - `obtacle_y+OBS_H > dino_y`
- Pass detection:
  - `prev_x` registers `obtacle_x` every cycle.
  - `pass = (prev_x >= DINO_X) && (obtacle_x < DINO_X)`.
- FSM:
  - IDLE: `score` is held at 0. `jump_rise` → RUN.
  - RUN:
    - Overlap → OVER. On that edge `collide` = 1 and `hi_score <= max(hi_score, score)`.
    - Else if `pass`, `score` increments by 1, saturating at 16'hFFFF.
  - OVER:
    - `score` is frozen.
    - The hold counter loads `HOLD_CYC-1` on entry and decrements to 0.
    - While the counter is nonzero, `jump_rise` is ignored.
    - When the counter is 0 and `jump_rise` occurs → IDLE, and `score` clears to 0 on that edge.
- Priority: overlap beats pass in the same cycle. That pass does not score.
- A wrap of the obstacle x position (small x to 896) is not a pass, because `prev_x < obtacle_x`.

## Timing
- Reset values:
  - `state` = IDLE
  - `score` = 0
  - `hi_score` = 0
  - `collide` = 0
  - `jump_q` = 0
  - `prev_x` = 0
  - hold counter = 0
- Reset is asynchronous at assertion and is taken regardless of state, so a mid-game reset returns to IDLE with `hi_score` cleared.
- All outputs are registered. There is no combinational path from any input to any output.
- `jump` rising in cycle n means `state` changes after edge n (1-cycle latency).
- Overlap sampled in cycle n means `state` = OVER and `collide` = 1 after edge n. `collide` returns to 0 after edge n+1.
- `pass` in cycle n means `score` updates after edge n.
- OVER lockout lasts `HOLD_CYC` cycles counted from entry. `jump_rise` is accepted in the first cycle the counter reads 0.
- A `jump` held high across the end of the lockout does not restart the game. A fresh rising edge is required.

## Structure
- Shared package `game_pkg` holds:
  - state encodings `ST_IDLE`, `ST_RUN`, `ST_OVER` (2 bits).
  - geometry defaults (`DINO_X`, `DINO_W`, `DINO_H`, `OBS_W`, `OBS_H`).
  - obstacle reset position `OBS_X0`=900 and `OBS_Y0`=400.
- The obstacle mover and the renderer import the same package.
- One sub-module, `box_overlap`: purely combinational two-box intersect, parameterized by widths and heights, with 11-bit internal sums.

## Test plan
All scenarios use `HOLD_CYC`=8.

1. Reset and start:
   - Stimulus: release `rst_n`, then pulse `jump` for 1 cycle.
   - Required: `state` 00→01 one cycle later, `score`=0.
2. Pass scoring:
   - Stimulus: in RUN with `dino_y`=300 and `obtacle_y`=400, step `obtacle_x` 103→100→97.
   - Required: `score` 0→1 exactly once, after the 100→97 step.
   - Stimulus: then step 3→896.
   - Required: no increment.
3. Collision:
   - Stimulus: in RUN, `dino_y`=380, `obtacle_y`=400, `obtacle_x`=130.
   - Required: next cycle `state`=10, `collide` high for 1 cycle, `hi_score`=`score`.
4. Overlap and pass in the same cycle:
   - Stimulus: `prev_x`=101, `obtacle_x`=98, boxes overlapping.
   - Required: OVER, with `score` unchanged.
5. Lockout:
   - Stimulus: in OVER, pulse `jump` at entry+3.
   - Required: ignored.
   - Stimulus: hold `jump` high from entry+5 to entry+12.
   - Required: stays OVER.
   - Stimulus: release, then pulse again.
   - Required: IDLE, `score`=0, `hi_score` kept.
6. Mid-run reset and saturation:
   - Stimulus: preload `score` to 16'hFFFE and apply 3 passes.
   - Required: `score`=16'hFFFF.
   - Stimulus: assert `rst_n`=0 mid-RUN.
   - Required: `state`=00 and `score`=`hi_score`=0 immediately, without waiting for a clock.
